feat_bram_reader: RTL and testbench

FEAT_BRAM_READER -- requirements
Module: feat_bram_reader

---
 rtl/feat_bram_reader.sv | 174 +++++++++++++++++
 tb/tb_feat_bram_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feat_bram_reader.sv
// Feature BRAM reader: credit-limited word reads streamed on AXI-stream, first m_tvalid RD_LAT+2 cycles after start.
// m_tready low stalls new issue only, never in-flight returns; define FEAT_RD_CHECKSUM_EN to add the checksum output.
module feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LAT             = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  output logic                          feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done
`ifdef FEAT_RD_CHECKSUM_EN
  ,
  output logic [NEW_FEATURE_WIDTH-1:0]  checksum
`endif
);

  localparam int CW = NEW_FEATURE_ADDR_W + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] MAX_LEN  = CW'(NEW_FEATURE_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [OW:0]   CREDITS  = (OW + 1)'(FIFO_DEPTH);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("feat_bram_reader: RD_LAT must be 1 or 2");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_fifo_depth
    $error("feat_bram_reader: FIFO_DEPTH must be at least RD_LAT+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                       state_q;
  logic [CW-1:0]                len_q;
  logic [CW-1:0]                issued_q;
  logic [CW-1:0]                sent_q;
  logic [RD_LAT-1:0]            vld_sr_q;
  logic [RD_LAT-1:0]            vld_sr_d;
  logic [NEW_FEATURE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q;
  logic [PW-1:0]                rd_ptr_q;
  logic [OW-1:0]                occ_q;
  logic                         done_q;

  logic          issue;
  logic          push;
  logic          pop;
  logic [OW:0]   inflight_d;
  logic [OW:0]   credit_used_d;
  logic [CW-1:0] len_d;

  // Every read still in the BRAM pipeline already owns a FIFO slot.
  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_d = inflight_d + (OW + 1)'(vld_sr_q[i]);
    end
  end

  assign credit_used_d = inflight_d + {1'b0, occ_q};
  assign issue         = (state_q == S_READ) && (issued_q < len_q) && (credit_used_d < CREDITS);
  assign push          = vld_sr_q[RD_LAT-1];
  assign pop           = m_tvalid && m_tready;
  assign len_d         = (num_words > MAX_LEN) ? MAX_LEN : num_words;

  if (RD_LAT == 1) begin : g_sr1
    assign vld_sr_d = issue;
  end else begin : g_srn
    assign vld_sr_d = {vld_sr_q[RD_LAT-2:0], issue};
  end

  assign feat_bram_enb   = issue;
  assign feat_bram_addrb = {issued_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
  assign m_tvalid        = (occ_q != '0);
  assign m_tdata         = mem_q[rd_ptr_q];
  assign m_tlast         = m_tvalid && (sent_q == len_q - CW'(1));
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= feat_bram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      vld_sr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      vld_sr_q <= vld_sr_d;
      done_q   <= (state_q == S_DONE);

      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        sent_q   <= sent_q + CW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + OW'(1);
      end else if (!push && pop) begin
        occ_q <= occ_q - OW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q    <= len_d;
            issued_q <= '0;
            sent_q   <= '0;
            state_q  <= (num_words == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            issued_q <= issued_q + CW'(1);
            if (issued_q + CW'(1) == len_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FEAT_RD_CHECKSUM_EN
  logic [NEW_FEATURE_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + m_tdata;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_feat_bram_reader.sv
// Two readers (RD_LAT 1 and 2) share stimulus; each is scored against a transfer-level model of its stream.
`timescale 1ns/1ps
module tb_feat_bram_reader;
  localparam int W     = 32;
  localparam int DEPTH = 43328;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int FD    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          m_tready;
  logic [CW-1:0] nw [2];
  logic [AW+1:0] addrb_w [2];
  logic          enb_w [2];
  logic          tvalid_w [2];
  logic          tlast_w [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic [W-1:0]  dout_w [2];
  logic [W-1:0]  tdata_w [2];
`ifdef FEAT_RD_CHECKSUM_EN
  logic [W-1:0]  cks_w [2];
`endif
  logic [W-1:0]  salt;
  logic [W-1:0]  rd0_q, rd1a_q, rd1b_q;

  // BRAM contents: plain index when salt is zero, otherwise a scrambled pattern.
  function automatic logic [W-1:0] word_of(input int idx);
    logic [W-1:0] v;
    v = W'(idx);
    return (salt == '0) ? v : ((v * 32'h9E3779B1) ^ salt);
  endfunction

  always @(posedge clk) begin
    if (enb_w[0]) rd0_q <= word_of(int'(addrb_w[0] >> 2));
    if (enb_w[1]) rd1a_q <= word_of(int'(addrb_w[1] >> 2));
    rd1b_q <= rd1a_q;
  end
  assign dout_w[0] = rd0_q;
  assign dout_w[1] = rd1b_q;

  feat_bram_reader #(.RD_LAT(1), .FIFO_DEPTH(FD)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .num_words(nw[0]),
    .feat_bram_addrb(addrb_w[0]), .feat_bram_enb(enb_w[0]), .feat_bram_dout(dout_w[0]),
    .m_tdata(tdata_w[0]), .m_tvalid(tvalid_w[0]), .m_tready(m_tready), .m_tlast(tlast_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
`ifdef FEAT_RD_CHECKSUM_EN
    , .checksum(cks_w[0])
`endif
  );

  feat_bram_reader #(.RD_LAT(2), .FIFO_DEPTH(FD)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .num_words(nw[1]),
    .feat_bram_addrb(addrb_w[1]), .feat_bram_enb(enb_w[1]), .feat_bram_dout(dout_w[1]),
    .m_tdata(tdata_w[1]), .m_tvalid(tvalid_w[1]), .m_tready(m_tready), .m_tlast(tlast_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
`ifdef FEAT_RD_CHECKSUM_EN
    , .checksum(cks_w[1])
`endif
  );

  int total, passed, cyc, rmode, rph;
  bit rst_pend;
  bit act_m [2];
  int len_m [2], iss_m [2], snt_m [2], st_cyc [2], due_m [2];
  int words_m [2], done_cnt [2], done_lat [2], last_addr [2], tlast_idx [2];
  logic [W-1:0] sum_m [2], last_dat [2], prev_dat [2], cks_done [2];
  bit prev_stall [2], prev_last [2];

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_cycle();
    bit legal;
    int lat;
    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      if (rst_pend) begin
        chk_eq("rst_enb", enb_w[k], 0);
        chk_eq("rst_tvalid", tvalid_w[k], 0);
        chk_eq("rst_tlast", tlast_w[k], 0);
        chk_eq("rst_busy", busy_w[k], 0);
        chk_eq("rst_done", done_w[k], 0);
        chk_eq("rst_addrb", addrb_w[k], 0);
      end
      if (rst) begin
        act_m[k] = 0;
        prev_stall[k] = 0;
        due_m[k] = -1;
        continue;
      end
      chk_eq("done", done_w[k], (act_m[k] && due_m[k] == cyc) ? 1 : 0);
      if (act_m[k] && due_m[k] == cyc) begin
        act_m[k] = 0;
        done_cnt[k]++;
        done_lat[k] = cyc - st_cyc[k];
`ifdef FEAT_RD_CHECKSUM_EN
        cks_done[k] = cks_w[k];
        chk_eq("checksum", cks_w[k], sum_m[k]);
`endif
      end
      chk_eq("busy", busy_w[k], (act_m[k] && cyc > st_cyc[k]) ? 1 : 0);
      if (enb_w[k]) begin
        legal = act_m[k] && (iss_m[k] < len_m[k]) && (iss_m[k] - snt_m[k] < FD);
        chk_eq("enb_legal", 1, legal);
        if (legal) begin
          chk_eq("addrb", addrb_w[k], iss_m[k] * 4);
          last_addr[k] = int'(addrb_w[k]);
          iss_m[k]++;
        end
      end
      if (act_m[k] && len_m[k] > 0 && cyc == st_cyc[k] + 1)
        chk_eq("first_enb", enb_w[k], 1);
      if (act_m[k] && len_m[k] > 0 && snt_m[k] == 0 && cyc <= st_cyc[k] + lat + 2)
        chk_eq("first_valid", tvalid_w[k], (cyc == st_cyc[k] + lat + 2) ? 1 : 0);
      if (prev_stall[k]) begin
        chk_eq("hold_valid", tvalid_w[k], 1);
        chk_eq("hold_data", tdata_w[k], prev_dat[k]);
        chk_eq("hold_last", tlast_w[k], prev_last[k]);
      end
      if (tvalid_w[k]) begin
        legal = act_m[k] && (snt_m[k] < len_m[k]);
        chk_eq("valid_legal", 1, legal);
        if (legal) chk_eq("tlast", tlast_w[k], (snt_m[k] == len_m[k] - 1) ? 1 : 0);
        if (legal && m_tready) begin
          chk_eq("tdata", tdata_w[k], word_of(snt_m[k]));
          sum_m[k] = sum_m[k] + tdata_w[k];
          last_dat[k] = tdata_w[k];
          if (tlast_w[k]) tlast_idx[k] = snt_m[k];
          snt_m[k]++;
          words_m[k]++;
          if (snt_m[k] == len_m[k]) due_m[k] = cyc + 2;
        end
      end else begin
        chk_eq("tlast_idle", tlast_w[k], 0);
      end
      prev_stall[k] = tvalid_w[k] && !m_tready;
      prev_dat[k] = tdata_w[k];
      prev_last[k] = tlast_w[k];
      if (start && !act_m[k]) begin
        act_m[k] = 1;
        len_m[k] = (int'(nw[k]) > DEPTH) ? DEPTH : int'(nw[k]);
        iss_m[k] = 0;
        snt_m[k] = 0;
        st_cyc[k] = cyc;
        due_m[k] = (len_m[k] == 0) ? cyc + 2 : -1;
        sum_m[k] = '0;
        words_m[k] = 0;
        tlast_idx[k] = -1;
      end
    end
    rst_pend = rst;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      0: m_tready = 1'b1;
      1: begin
        m_tready = (rph == 0 || rph == 3);
        rph = (rph + 1) % 4;
      end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic pulse_start(input int a, input int b);
    nw[0] = CW'(a);
    nw[1] = CW'(b);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n;
    n = 0;
    while ((act_m[0] || act_m[1]) && n < bound) begin
      step();
      n++;
    end
    chk_eq(nm, (act_m[0] || act_m[1]) ? 1 : 0, 0);
  endtask

  int dc0, dc1, a, b;

  initial begin
    total = 0; passed = 0; cyc = 0; rmode = 0; rph = 0; rst_pend = 0;
    rst = 1'b1; start = 1'b0; m_tready = 1'b1; salt = '0;
    nw[0] = '0; nw[1] = '0;
    for (int k = 0; k < 2; k++) begin
      act_m[k] = 0; due_m[k] = -1; prev_stall[k] = 0; done_cnt[k] = 0;
      words_m[k] = 0; tlast_idx[k] = -1; st_cyc[k] = 0; len_m[k] = 0;
      iss_m[k] = 0; snt_m[k] = 0; sum_m[k] = '0; cks_done[k] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    // 16 words, index data, always ready
    dc0 = done_cnt[0]; dc1 = done_cnt[1];
    pulse_start(16, 16);
    wait_idle(200, "timeout_a");
    chk_eq("a_words", words_m[0], 16);
    chk_eq("a_last_data", last_dat[0], 15);
    chk_eq("a_last_addr", last_addr[0], 60);
    chk_eq("a_tlast_idx", tlast_idx[0], 15);
    chk_eq("a_done_cnt0", done_cnt[0] - dc0, 1);
    chk_eq("a_done_cnt1", done_cnt[1] - dc1, 1);
    chk_eq("a_words_lat2", words_m[1], 16);
`ifdef FEAT_RD_CHECKSUM_EN
    chk_eq("a_checksum0", cks_done[0], 120);
    chk_eq("a_checksum1", cks_done[1], 120);
`endif
    repeat (2) step();

    // 8 words under a 1,0,0,1 ready pattern
    rmode = 1; rph = 0;
    pulse_start(8, 8);
    wait_idle(300, "timeout_b");
    chk_eq("b_words0", words_m[0], 8);
    chk_eq("b_words1", words_m[1], 8);
    chk_eq("b_last_data", last_dat[0], 7);
    rmode = 0;
    repeat (2) step();

    // zero-length transfer
    pulse_start(0, 0);
    wait_idle(20, "timeout_c");
    chk_eq("c_done_lat0", done_lat[0], 2);
    chk_eq("c_done_lat1", done_lat[1], 2);
    chk_eq("c_words", words_m[0], 0);
    repeat (2) step();

    // reset mid-transfer, then a short transfer
    pulse_start(16, 16);
    a = 0;
    while (snt_m[0] < 5 && a < 200) begin
      step();
      a++;
    end
    chk_eq("d_reached_word5", snt_m[0], 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    pulse_start(4, 4);
    wait_idle(100, "timeout_d");
    chk_eq("d_words0", words_m[0], 4);
    chk_eq("d_words1", words_m[1], 4);
    chk_eq("d_last_data", last_dat[0], 3);

    // randomized lengths, data and backpressure, with a start pulse landing mid-transfer
    for (int t = 0; t < 6; t++) begin
      salt = $urandom | 32'd1;
      rmode = 2;
      a = $urandom_range(1, 40);
      b = $urandom_range(1, 40);
      pulse_start(a, b);
      repeat (3) step();
      pulse_start(5, 7);
      wait_idle(3000, "timeout_rand");
      repeat ($urandom_range(0, 3)) step();
    end

    // full-depth transfer: clamp on reader 0, exact depth on the RD_LAT=2 reader
    salt = '0;
    rmode = 0;
    repeat (2) step();
    pulse_start(100000, DEPTH);
    repeat (100) step();
    pulse_start(3, 3);
    wait_idle(50000, "timeout_big");
    chk_eq("f_words0", words_m[0], DEPTH);
    chk_eq("f_words1", words_m[1], DEPTH);
    chk_eq("f_last_addr1", last_addr[1], 173308);
    chk_eq("f_last_addr0", last_addr[0], 173308);
    chk_eq("f_tlast_idx1", tlast_idx[1], 43327);
    chk_eq("f_last_data1", last_dat[1], 43327);
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
